// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed seven-segment driver.
// A shadow register holds DIGITS hex nibbles plus decimal points. A divider
// advances a digit index every SCAN_DIV cycles. A single decoder drives a
// shared active-low segment bus with one active-low anode per digit.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress the segments of
// leading zero digits. Digit 0 is never suppressed.
module hex_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // Lookup tables are padded to a power of two so any idx value is a legal index
    localparam int PAD_N = 1 << IDX_W;

    logic [4*DIGITS-1:0] val_q_reg;
    logic [DIGITS-1:0]   dp_q_reg;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                adv;

    logic [6:0]          seg_n_reg, seg_n_next;
    logic                dp_n_reg, dp_n_next;
    logic [DIGITS-1:0]   an_n_reg, an_n_next;

    logic [3:0]          nib_arr [PAD_N];
    logic [PAD_N-1:0]    dp_vec;
    logic                suppress;

    assign adv = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));

    // Shadow register: outputs only ever show latched data
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q_reg <= '0;
            dp_q_reg  <= '0;
        end else if (load) begin
            val_q_reg <= value;
            dp_q_reg  <= dp_in;
        end
    end

    // Scan divider and digit index; keep running while blanked to preserve phase
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            idx_reg     <= '0;
        end else begin
            if (adv) begin
                div_cnt_reg <= '0;
                if (idx_reg == IDX_W'(DIGITS - 1))
                    idx_reg <= '0;
                else
                    idx_reg <= idx_reg + IDX_W'(1);
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
        end
    end

    // Unpack nibbles and decimal points into idx-addressable tables
    genvar gi;
    generate
        for (gi = 0; gi < PAD_N; gi++) begin : g_unpack
            if (gi < DIGITS) begin : g_real
                assign nib_arr[gi] = val_q_reg[4*gi +: 4];
                assign dp_vec[gi]  = dp_q_reg[gi];
            end else begin : g_pad
                assign nib_arr[gi] = 4'h0;
                assign dp_vec[gi]  = 1'b0;
            end
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // lz_mask[i] = 1 when digits DIGITS-1 down to i are all zero (i > 0)
    logic [PAD_N-1:0] lz_mask;
    generate
        for (gi = 0; gi < PAD_N; gi++) begin : g_lz
            if (gi == 0 || gi >= DIGITS) begin : g_never
                assign lz_mask[gi] = 1'b0;
            end else begin : g_cmp
                assign lz_mask[gi] = (val_q_reg[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate
    assign suppress = lz_mask[idx_reg];
`else
    assign suppress = 1'b0;
`endif

    // Next output values: decode the current digit, or all-off when blanked
    always_comb begin
        seg_n_next = 7'h7F;
        dp_n_next  = 1'b1;
        an_n_next  = '1;
        if (!blank) begin
            if (!suppress) begin
                case (nib_arr[idx_reg])
                    4'h0: seg_n_next = 7'b0000001;
                    4'h1: seg_n_next = 7'b1001111;
                    4'h2: seg_n_next = 7'b0010010;
                    4'h3: seg_n_next = 7'b0000110;
                    4'h4: seg_n_next = 7'b1001100;
                    4'h5: seg_n_next = 7'b0100100;
                    4'h6: seg_n_next = 7'b0100000;
                    4'h7: seg_n_next = 7'b0001111;
                    4'h8: seg_n_next = 7'b0000000;
                    4'h9: seg_n_next = 7'b0000100;
                    4'hA: seg_n_next = 7'b0001000;
                    4'hB: seg_n_next = 7'b1100000;
                    4'hC: seg_n_next = 7'b0110001;
                    4'hD: seg_n_next = 7'b1000010;
                    4'hE: seg_n_next = 7'b0110000;
                    default: seg_n_next = 7'b0111000;
                endcase
            end
            dp_n_next = ~dp_vec[idx_reg];
            an_n_next = ~(DIGITS'(1) << idx_reg);
        end
    end

    // Output register: segments, point and anodes switch on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n_reg <= 7'h7F;
            dp_n_reg  <= 1'b1;
            an_n_reg  <= '1;
        end else begin
            seg_n_reg <= seg_n_next;
            dp_n_reg  <= dp_n_next;
            an_n_reg  <= an_n_next;
        end
    end

    assign seg_n = seg_n_reg;
    assign dp_n  = dp_n_reg;
    assign an_n  = an_n_reg;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Testbench for hex_scan_driver: a 4-digit/SCAN_DIV=4 instance and a
// 1-digit/SCAN_DIV=1 instance, checked with directed vectors.
module tb_hex_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    logic        b_load;
    logic [3:0]  b_value;
    logic [0:0]  b_dp_in;
    logic        b_blank;
    logic [6:0]  b_seg_n;
    logic        b_dp_n;
    logic [0:0]  b_an_n;

    int total = 0;
    int bad   = 0;
    int t     = 0;   // number of the last edge since reset release (edge 0)

    always #5 clk = ~clk;

    hex_scan_driver #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank(blank), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
    );

    hex_scan_driver #(.DIGITS(1), .SCAN_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .load(b_load), .value(b_value), .dp_in(b_dp_in),
        .blank(b_blank), .seg_n(b_seg_n), .dp_n(b_dp_n), .an_n(b_an_n)
    );

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Digit lit after edge tt when the scan restarted at edge 0
    function automatic int exp_idx(input int tt);
        return (tt / SD) % D;
    endfunction

    function automatic logic [3:0] exp_an(input int tt);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << exp_idx(tt));
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int tt);
        logic [3:0] nib;
        nib = v[4*exp_idx(tt) +: 4];
        return dec(nib);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Reset both DUTs, then load v/dp on edge 0 (the first edge with rst=0)
    task automatic do_reset_load(input logic [15:0] v, input logic [3:0] dp);
        rst = 1'b1; load = 1'b0; blank = 1'b0; b_load = 1'b0; b_blank = 1'b0;
        step();
        step();
        rst = 1'b0; value = v; dp_in = dp; load = 1'b1;
        t = -1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset_load(16'h1234, 4'b0000);
        repeat (6) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (seg_n !== 7'h7F) begin bad++; $display("FAIL reset_seg cyc=%0d got=%b want=1111111", i, seg_n); end
            total++;
            if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dp cyc=%0d got=%b want=1", i, dp_n); end
            total++;
            if (an_n !== 4'hF) begin bad++; $display("FAIL reset_an cyc=%0d got=%h want=f", i, an_n); end
        end
        rst = 1'b0;
        t = -1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (an_n !== exp_an(t)) begin bad++; $display("FAIL release_an t=%0d got=%h want=%h", t, an_n, exp_an(t)); end
            if (t < SD) begin
                total++;
                if (seg_n !== 7'b0000001) begin bad++; $display("FAIL release_seg t=%0d got=%b want=0000001", t, seg_n); end
            end
        end
    endtask

    task automatic test_scan();
        do_reset_load(16'h1234, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (an_n !== exp_an(t)) begin bad++; $display("FAIL scan_an t=%0d got=%h want=%h", t, an_n, exp_an(t)); end
            total++;
            if (seg_n !== exp_seg(16'h1234, t)) begin bad++; $display("FAIL scan_seg t=%0d got=%b want=%b", t, seg_n, exp_seg(16'h1234, t)); end
        end
    endtask

    task automatic test_load_mid();
        do_reset_load(16'h1234, 4'b0000);
        step();
        total++;
        if (seg_n !== 7'b1001100) begin bad++; $display("FAIL load_mid_pre got=%b want=1001100", seg_n); end
        value = 16'h123F; load = 1'b1;
        step();
        load = 1'b0;
        total++;
        if (seg_n !== 7'b1001100) begin bad++; $display("FAIL load_mid_edge got=%b want=1001100", seg_n); end
        step();
        total++;
        if (seg_n !== 7'b0111000) begin bad++; $display("FAIL load_mid_after got=%b want=0111000", seg_n); end
        total++;
        if (an_n !== 4'hE) begin bad++; $display("FAIL load_mid_an got=%h want=e", an_n); end
    endtask

    task automatic test_back_to_back();
        do_reset_load(16'h1234, 4'b0000);
        step();
        step();
        value = 16'h5678; load = 1'b1;
        step();
        load = 1'b0;
        total++;
        if (seg_n !== 7'b1001100 || an_n !== 4'hE) begin bad++; $display("FAIL b2b_edge got=%b/%h want=1001100/e", seg_n, an_n); end
        step();
        total++;
        if (an_n !== 4'hD) begin bad++; $display("FAIL b2b_an got=%h want=d", an_n); end
        total++;
        if (seg_n !== 7'b0001111) begin bad++; $display("FAIL b2b_seg got=%b want=0001111", seg_n); end
    endtask

    task automatic test_dp_blank();
        do_reset_load(16'h1234, 4'b0100);
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (dp_n !== ((exp_idx(t) == 2) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL dp t=%0d got=%b an=%h", t, dp_n, an_n); end
        end
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (seg_n !== 7'h7F || dp_n !== 1'b1 || an_n !== 4'hF) begin
                bad++; $display("FAIL blank t=%0d got=%b/%b/%h want=1111111/1/f", t, seg_n, dp_n, an_n);
            end
        end
        blank = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (an_n !== exp_an(t)) begin bad++; $display("FAIL unblank_an t=%0d got=%h want=%h", t, an_n, exp_an(t)); end
            total++;
            if (seg_n !== exp_seg(16'h1234, t)) begin bad++; $display("FAIL unblank_seg t=%0d got=%b want=%b", t, seg_n, exp_seg(16'h1234, t)); end
        end
    endtask

    task automatic test_lzb();
        logic [6:0] lead;
`ifdef LEADING_ZERO_BLANK_EN
        lead = 7'h7F;
`else
        lead = 7'b0000001;
`endif
        do_reset_load(16'h0030, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            logic [6:0] want;
            step();
            case (exp_idx(t))
                0: want = 7'b0000001;
                1: want = 7'b0000110;
                default: want = lead;
            endcase
            total++;
            if (seg_n !== want) begin bad++; $display("FAIL lzb_0030 t=%0d got=%b want=%b", t, seg_n, want); end
        end
        do_reset_load(16'h0000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            logic [6:0] want;
            step();
            want = (exp_idx(t) == 0) ? 7'b0000001 : lead;
            total++;
            if (seg_n !== want) begin bad++; $display("FAIL lzb_0000 t=%0d got=%b want=%b", t, seg_n, want); end
            total++;
            if (an_n !== exp_an(t)) begin bad++; $display("FAIL lzb_an t=%0d got=%h want=%h", t, an_n, exp_an(t)); end
        end
    endtask

    task automatic test_boundary();
        do_reset_load(16'h0000, 4'b0000);
        for (int n = 0; n <= 16; n++) begin
            if (n < 16) begin
                b_value = 4'(n); b_dp_in = 1'(n); b_load = 1'b1;
            end else begin
                b_load = 1'b0;
            end
            step();
            if (n > 0) begin
                logic [3:0] pv;
                pv = 4'(n - 1);
                total++;
                if (b_seg_n !== dec(pv)) begin bad++; $display("FAIL bnd_seg v=%h got=%b want=%b", pv, b_seg_n, dec(pv)); end
                total++;
                if (b_an_n !== 1'b0) begin bad++; $display("FAIL bnd_an v=%h got=%b want=0", pv, b_an_n); end
                total++;
                if (b_dp_n !== ~pv[0]) begin bad++; $display("FAIL bnd_dp v=%h got=%b want=%b", pv, b_dp_n, ~pv[0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank = 1'b0;
        b_load = 1'b0; b_value = '0; b_dp_in = '0; b_blank = 1'b0;
        test_reset();
        test_scan();
        test_load_mid();
        test_back_to_back();
        test_dp_blank();
        test_lzb();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
